// File: rtl/four_two_encoder.sv
// four_two_encoder: registered 4-to-2 priority encoder with request capture.
// Four active-low asynchronous request lines are synchronised, falling-edge
// captured into pending bits, and the highest-index pending request is
// presented as a 2-bit code under a valid/ack handshake.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   Cs             active-low enable for starting a new grant
//   R0..R3         active-low request lines (asynchronous to clk)
//   ack            consumer accepts the presented code
//   A1, A0         presented code (registered)
//   valid          code on A1,A0 is valid (registered)
//   pend[3:0]      pending request bits (registered)
module four_two_encoder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Cs,
    input  logic       R0,
    input  logic       R1,
    input  logic       R2,
    input  logic       R3,
    input  logic       ack,
    output logic       A1,
    output logic       A0,
    output logic       valid,
    output logic [3:0] pend
);

    localparam int unsigned NREQ   = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    logic [NREQ-1:0]                  req_raw;
    logic [SYNC_STAGES-1:0][NREQ-1:0] sync_q;
    logic [NREQ-1:0]                  sync_out;
    logic [NREQ-1:0]                  hist_q;
    logic [SYNC_STAGES-1:0]           fill_q;
    logic [NREQ-1:0]                  armed_q;
    logic [NREQ-1:0]                  armed_d;
    logic [NREQ-1:0]                  fall;

    state_e              state_q;
    state_e              state_d;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_d;
    logic                valid_q;
    logic                valid_d;
    logic [NREQ-1:0]     pend_q;
    logic [NREQ-1:0]     pend_d;
    logic [NREQ-1:0]     clr_mask;

    assign req_raw  = {R3, R2, R1, R0};
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Highest set index wins.
    function automatic logic [CODE_W-1:0] prio_code(input logic [NREQ-1:0] p);
        if (p[3])      return CODE_W'(3);
        else if (p[2]) return CODE_W'(2);
        else if (p[1]) return CODE_W'(1);
        else           return CODE_W'(0);
    endfunction

    // A line is armed only once its synchronised value has been seen high
    // after reset; fill_q marks when the sync chain holds real pin samples.
    // This keeps a line already low at reset release from being captured.
    assign armed_d = armed_q | (sync_out & {NREQ{fill_q[SYNC_STAGES-1]}});
    assign fall    = armed_q & hist_q & ~sync_out;

    // Synchroniser, history and arming flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            hist_q  <= '1;
            fill_q  <= '0;
            armed_q <= '0;
        end else begin
            sync_q[0] <= req_raw;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q  <= sync_out;
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!Cs && (pend_q != '0)) state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic; a new capture overrides a same-cycle clear.
    always_comb begin
        code_d   = code_q;
        valid_d  = 1'b0;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (!Cs && (pend_q != '0)) begin
                    code_d  = prio_code(pend_q);
                    valid_d = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (ack) clr_mask = NREQ'(1) << code_q;
                else     valid_d  = 1'b1;
            end
            default: ;
        endcase
        pend_d = (pend_q & ~clr_mask) | fall;
    end

    assign A1    = code_q[1];
    assign A0    = code_q[0];
    assign valid = valid_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_four_two_encoder.sv
// Bench for four_two_encoder: a sample-history model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_four_two_encoder;

    localparam int unsigned S = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       Cs    = 1'b0;
    logic       R0    = 1'b1;
    logic       R1    = 1'b1;
    logic       R2    = 1'b1;
    logic       R3    = 1'b1;
    logic       ack   = 1'b0;
    logic       A1;
    logic       A0;
    logic       valid;
    logic [3:0] pend;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int grant_cnt;

    four_two_encoder #(.SYNC_STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Cs    (Cs),
        .R0    (R0),
        .R1    (R1),
        .R2    (R2),
        .R3    (R3),
        .ack   (ack),
        .A1    (A1),
        .A0    (A0),
        .valid (valid),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    // Model: keeps raw pin samples since reset; a capture happens S edges
    // after a sample that is low while the sample before it was high.
    logic [3:0] m_hist[$];
    logic [3:0] m_pend = 4'b0000;
    logic [3:0] m_fall;
    logic [1:0] m_code = 2'b00;
    bit         m_busy = 1'b0;

    function automatic logic [1:0] top_index(input logic [3:0] p);
        logic [1:0] h;
        h = 2'b00;
        for (int i = 0; i < 4; i++) if (p[i]) h = 2'(i);
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist.delete();
            m_pend = 4'b0000;
            m_code = 2'b00;
            m_busy = 1'b0;
        end else begin
            m_hist.push_front({R3, R2, R1, R0});
            if (m_hist.size() > S + 2) void'(m_hist.pop_back());
            m_fall = 4'b0000;
            if (m_hist.size() == S + 2) m_fall = m_hist[S+1] & ~m_hist[S];
            if (m_busy) begin
                if (ack) begin
                    m_pend[m_code] = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (!Cs && m_pend != 4'b0000) begin
                m_code = top_index(m_pend);
                m_busy = 1'b1;
            end
            m_pend = m_pend | m_fall;
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", {3'b000, valid}, {3'b000, m_busy});
            chk("model_code",  {2'b00, A1, A0}, {2'b00, m_code});
            chk("model_pend",  pend, m_pend);
        end
    end

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        nedge(1);
        chk("rst_valid", {3'b000, valid}, 4'b0000);
        chk("rst_code",  {2'b00, A1, A0}, 4'b0000);
        chk("rst_pend",  pend, 4'b0000);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        nedge(4);

        // Single request on R2
        R2 = 1'b0; nedge(1); R2 = 1'b1;
        nedge(1); chk("single_pend_k1", pend, 4'b0000);
        nedge(1); chk("single_pend_k2", pend, 4'b0100);
        chk("single_valid_k2", {3'b000, valid}, 4'b0000);
        nedge(1); chk("single_valid_k3", {3'b000, valid}, 4'b0001);
        chk("single_code_k3", {2'b00, A1, A0}, 4'b0010);
        nedge(3); chk("single_hold", {3'b000, valid}, 4'b0001);
        ack = 1'b1; nedge(1); ack = 1'b0;
        chk("single_ack_valid", {3'b000, valid}, 4'b0000);
        chk("single_ack_pend", pend, 4'b0000);
        nedge(2);

        // Priority: R0 and R3 together, ack tied high
        ack = 1'b1;
        R0 = 1'b0; R3 = 1'b0; nedge(1); R0 = 1'b1; R3 = 1'b1;
        nedge(2); chk("prio_pend", pend, 4'b1001);
        nedge(1); chk("prio_g1_valid", {3'b000, valid}, 4'b0001);
        chk("prio_g1_code", {2'b00, A1, A0}, 4'b0011);
        nedge(1); chk("prio_gap", {3'b000, valid}, 4'b0000);
        chk("prio_gap_pend", pend, 4'b0001);
        nedge(1); chk("prio_g2_valid", {3'b000, valid}, 4'b0001);
        chk("prio_g2_code", {2'b00, A1, A0}, 4'b0000);
        nedge(1); chk("prio_end_valid", {3'b000, valid}, 4'b0000);
        chk("prio_end_pend", pend, 4'b0000);
        ack = 1'b0;
        nedge(2);

        // Late higher-priority request does not preempt
        R1 = 1'b0; nedge(1); R1 = 1'b1;
        nedge(3); chk("late_code01", {2'b00, A1, A0}, 4'b0001);
        R3 = 1'b0; nedge(1); R3 = 1'b1;
        nedge(4); chk("late_hold_code", {2'b00, A1, A0}, 4'b0001);
        chk("late_pend", pend, 4'b1010);
        ack = 1'b1; nedge(1); ack = 1'b0;
        chk("late_ack_valid", {3'b000, valid}, 4'b0000);
        chk("late_ack_pend", pend, 4'b1000);
        nedge(1); chk("late_next_code", {2'b00, A1, A0}, 4'b0011);
        ack = 1'b1; nedge(1); ack = 1'b0;
        chk("late_clear", pend, 4'b0000);
        nedge(2);

        // Cs gating
        Cs = 1'b1;
        R1 = 1'b0; R2 = 1'b0; nedge(1); R1 = 1'b1; R2 = 1'b1;
        nedge(4); chk("cs_pend", pend, 4'b0110);
        chk("cs_blocked", {3'b000, valid}, 4'b0000);
        Cs = 1'b0; nedge(1);
        chk("cs_grant_valid", {3'b000, valid}, 4'b0001);
        chk("cs_grant_code", {2'b00, A1, A0}, 4'b0010);
        Cs = 1'b1; nedge(3);
        chk("cs_hold_valid", {3'b000, valid}, 4'b0001);
        ack = 1'b1; nedge(1); ack = 1'b0;
        chk("cs_ack_pend", pend, 4'b0010);
        nedge(2); chk("cs_idle_blocked", {3'b000, valid}, 4'b0000);
        Cs = 1'b0; nedge(1);
        chk("cs_regrant_code", {2'b00, A1, A0}, 4'b0001);
        ack = 1'b1; nedge(1); ack = 1'b0;
        chk("cs_clear", pend, 4'b0000);
        nedge(2);

        // Set/clear collision on pend[1]
        R1 = 1'b0; nedge(1); R1 = 1'b1;
        nedge(3); chk("coll_code", {2'b00, A1, A0}, 4'b0001);
        R1 = 1'b0; nedge(1); R1 = 1'b1;
        nedge(1); ack = 1'b1;
        nedge(1); ack = 1'b0;
        chk("coll_valid_drop", {3'b000, valid}, 4'b0000);
        chk("coll_pend_kept", pend, 4'b0010);
        nedge(1); chk("coll_repres_valid", {3'b000, valid}, 4'b0001);
        chk("coll_repres_code", {2'b00, A1, A0}, 4'b0001);
        ack = 1'b1; nedge(1); ack = 1'b0;
        chk("coll_clear", pend, 4'b0000);
        nedge(2);

        // Two falls of R0 merge into one grant
        Cs = 1'b1;
        R0 = 1'b0; nedge(1); R0 = 1'b1; nedge(3);
        R0 = 1'b0; nedge(1); R0 = 1'b1; nedge(4);
        chk("merge_pend", pend, 4'b0001);
        ack = 1'b1; Cs = 1'b0;
        grant_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            nedge(1);
            if (valid) grant_cnt++;
        end
        ack = 1'b0;
        chk("merge_grants", 4'(grant_cnt), 4'd1);
        chk("merge_clear", pend, 4'b0000);
        nedge(2);

        // Reset mid-PRESENT, R3 held low across release
        R1 = 1'b0; R3 = 1'b0; nedge(1); R1 = 1'b1;
        nedge(3);
        chk("rstmid_code", {2'b00, A1, A0}, 4'b0011);
        chk("rstmid_pend", pend, 4'b1010);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid0", {3'b000, valid}, 4'b0000);
        chk("rstmid_code0", {2'b00, A1, A0}, 4'b0000);
        chk("rstmid_pend0", pend, 4'b0000);
        nedge(1);
        #2 rst_n = 1'b1;
        nedge(6);
        chk("rstmid_nocap", pend, 4'b0000);
        chk("rstmid_novalid", {3'b000, valid}, 4'b0000);
        R3 = 1'b1; nedge(4);
        R3 = 1'b0; nedge(1); R3 = 1'b1;
        nedge(3);
        chk("rearm_valid", {3'b000, valid}, 4'b0001);
        chk("rearm_code", {2'b00, A1, A0}, 4'b0011);
        ack = 1'b1; nedge(1); ack = 1'b0;
        chk("rearm_clear", pend, 4'b0000);
        nedge(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/four_two_encoder.md
# four_two_encoder

Registered 4-to-2 priority encoder with request capture and a valid/ack handshake. It is the return path for the 2-to-4 chip-select decoder. Four active-low request lines (Y0..Y3 polarity) are synchronised and edge-captured into pending bits. The highest-index pending request is presented as a 2-bit code (A1,A0) to a single consumer.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on each request line (legal range 2..3).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Cs  input  1  active-low enable (1 = no new grant starts; capture continues).
- R0  input  1  request 0, active-low, asynchronous to clk.
- R1  input  1  request 1, active-low, asynchronous to clk.
- R2  input  1  request 2, active-low, asynchronous to clk.
- R3  input  1  request 3, active-low, asynchronous to clk.
- ack  input  1  consumer accepts the presented code (active-high).
- A1  output  1  code MSB, registered.
- A0  output  1  code LSB, registered.
- valid  output  1  code on A1,A0 is valid, registered.
- pend  output  4  pending request bits, pend[i] for Ri, registered.

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
**Synchroniser and capture**
- Each Ri passes through SYNC_STAGES flops, then one history flop.
- All of these flops reset to 1 (idle), so reset release produces no spurious edge.
- A falling edge (synchronised value 0, history value 1) sets pend[i].
- A level held low produces exactly one capture.
- A new falling edge on Ri while pend[i]=1 merges into the existing bit. No count or overflow is kept.

**FSM, two states**
- IDLE: valid=0.
  - If Cs=0 and pend!=0: register the code of the highest set index (R3 > R2 > R1 > R0) into A1,A0, set valid=1, and go to PRESENT.
  - Otherwise stay in IDLE; A1,A0 hold their last value.
- PRESENT: valid=1, A1,A0 stable.
  - If ack=1: clear pend[{A1,A0}], set valid=0, and go to IDLE.
  - Otherwise hold. Cs changes and new captures do not alter the presented code, even if they are of higher priority.

**Priority and enable rules**
- Priority is evaluated only at the IDLE->PRESENT transition.
- Cs=1 while in PRESENT does not withdraw valid. The grant completes normally on ack.

**Simultaneous events**
- Set and clear of the same pend bit in one cycle: set wins, so pend[i] stays 1 and the request is re-presented later.
- Captures on several lines in the same cycle all set their bits.
- ack while in IDLE is ignored.

## Timing
**Reset values:** A1=0, A0=0, valid=0, pend=4'b0000, FSM=IDLE, all synchroniser and history flops =1.

**Capture latency** (SYNC_STAGES=2):
- Ri low ahead of edge k.
- pend[i]=1 after edge k+2.
- valid=1 with the code after edge k+3, provided Cs=0 and the FSM is in IDLE.

**Handshake**
- Transfer occurs on an edge where valid=1 and ack=1.
- valid drops after that edge.
- Minimum one IDLE cycle between consecutive grants: sustained back-to-back throughput is one grant per 2 cycles.
- ack may be held high permanently; each grant is then 2 cycles.

**Reset mid-operation:** rst_n low at any time forces all reset values immediately (asynchronous). Pending requests are lost. Ri lines still low at reset release are not captured until they go high and fall again.

## Test plan
- **Reset:** assert rst_n=0 mid-PRESENT with pend=4'b1010 -> immediately valid=0, A1A0=00, pend=0000. After release with R3 held low: no capture.
- **Single request:** Cs=0, ack=0, pulse R2 low for 1 cycle at edge k -> pend=0100 after k+2, valid=1 and A1A0=10 after k+3. Stays valid until ack. ack for one cycle -> valid=0, pend=0000 on the next edge.
- **Priority:** R0 and R3 fall in the same cycle, ack tied high -> grants 11 then 00, each valid for 1 cycle, separated by exactly 1 idle cycle. pend ends at 0000.
- **Late higher priority:** R1 is granted (A1A0=01, ack=0), then R3 falls -> A1A0 stays 01 until ack. The next grant is 11.
- **Cs gating:** Cs=1, R1 and R2 fall -> pend=0110, valid stays 0. Cs->0 -> the next IDLE edge gives valid=1, A1A0=10. Cs->1 during PRESENT -> valid holds until ack.
- **Set/clear collision and merge:** R1 re-falls on the exact cycle its grant is acked -> pend[1] stays 1 and code 01 is re-presented after 1 idle cycle. Two falls of R0 before any grant -> exactly one grant of 00.
